// File: rtl/key_reverse_cam.sv
// key_reverse_cam: writable key/data table searched by data, returning the key and
// index of the lowest valid matching entry. One-deep registered result with
// valid/ready handshakes on request and response.
//   clk, rst                         clock, synchronous active-high reset
//   wr_en, wr_idx, wr_key, wr_data   entry write port (out-of-range wr_idx ignored)
//   clr                              invalidate all entries (wins over wr_en)
//   req_valid, req_ready, req_data   search request
//   resp_valid, resp_ready           search result handshake
//   resp_hit, resp_key, resp_idx     search result (all zero on miss)
module key_reverse_cam #(
  parameter  int NR_KEY   = 4,
  parameter  int KEY_LEN  = 2,
  parameter  int DATA_LEN = 8,
  localparam int IDX_LEN  = $clog2(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_LEN-1:0]  wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                clr,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_LEN-1:0] req_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_hit,
  output logic [KEY_LEN-1:0]  resp_key,
  output logic [IDX_LEN-1:0]  resp_idx
);

  typedef enum logic {
    EMPTY,
    FULL
  } state_t;

  state_t              state_q, state_d;
  logic [NR_KEY-1:0]   valid_q, valid_d;
  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [KEY_LEN-1:0]  key_d  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];
  logic [DATA_LEN-1:0] data_d [NR_KEY];
  logic                resp_hit_q, resp_hit_d;
  logic [KEY_LEN-1:0]  resp_key_q, resp_key_d;
  logic [IDX_LEN-1:0]  resp_idx_q, resp_idx_d;

  logic                accept;
  logic                match_hit;
  logic [KEY_LEN-1:0]  match_key;
  logic [IDX_LEN-1:0]  match_idx;

  assign req_ready  = (state_q == EMPTY) || resp_ready;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == FULL);
  assign resp_hit   = resp_hit_q;
  assign resp_key   = resp_key_q;
  assign resp_idx   = resp_idx_q;

  // Search runs on the registered table, so a same-cycle write/clr is not visible.
  always_comb begin
    match_hit = 1'b0;
    match_key = '0;
    match_idx = '0;
    for (int unsigned i = 0; i < NR_KEY; i++) begin
      if (!match_hit && valid_q[i] && (data_q[i] == req_data)) begin
        match_hit = 1'b1;
        match_key = key_q[i];
        match_idx = IDX_LEN'(i);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    data_d  = data_q;
    for (int unsigned i = 0; i < NR_KEY; i++) begin
      if (wr_en && (wr_idx == IDX_LEN'(i))) begin
        valid_d[i] = 1'b1;
        key_d[i]   = wr_key;
        data_d[i]  = wr_data;
      end
    end
    if (clr) begin
      valid_d = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    resp_hit_d = resp_hit_q;
    resp_key_d = resp_key_q;
    resp_idx_d = resp_idx_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept) begin
          state_d = FULL;
        end else if (resp_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      resp_hit_d = match_hit;
      resp_key_d = match_key;
      resp_idx_d = match_idx;
    end
  end

  always_ff @(posedge clk) begin
    key_q  <= key_d;
    data_q <= data_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      valid_q    <= '0;
      resp_hit_q <= 1'b0;
      resp_key_q <= '0;
      resp_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      resp_hit_q <= resp_hit_d;
      resp_key_q <= resp_key_d;
      resp_idx_q <= resp_idx_d;
    end
  end

endmodule
